// File: rtl/term_ctrl_if.sv
// term_ctrl_if: byte-stream valid/ready handshake plus the terminal-buffer memory port.
// Defines the shared memory-port macros (DATA_BUS width, MEM_READ / MEM_WRITE encodings).
// master = term_ctrl side, slave = source/buffer side.
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

interface term_ctrl_if;
  logic           char_valid;
  logic [7:0]     char_data;
  logic           char_ready;
  logic           mem_ena;
  logic           mem_rw;
  logic `DATA_BUS mem_addr;
  logic `DATA_BUS mem_wdata;
  logic `DATA_BUS mem_rdata;

  modport master (
    input  char_valid, char_data, mem_rdata,
    output char_ready, mem_ena, mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    output char_valid, char_data, mem_rdata,
    input  char_ready, mem_ena, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/term_ctrl.sv
// term_ctrl: interprets a byte stream (printable/LF/CR/BS/FF) into terminal-buffer writes, cursor, scroll, clear.
// Latency: a printable byte is written one cycle after acceptance; scroll takes 2*COLS*(ROWS-1)+COLS cycles, clear ROWS*COLS.
// Backpressure: char_ready is high only in IDLE; a byte held during PUT/scroll/clear waits. Macro TERM_CTRL_TAB_EN enables TAB.
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module term_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic        clk,
  input  logic        rst,
  term_ctrl_if.master bus,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CLS} state_t;

  localparam logic [4:0]    ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0]    COL_LAST = 7'(COLS - 1);
  localparam logic [AW-1:0] COLS_AW  = AW'(COLS);
  localparam logic [AW-1:0] MOVE_END = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] CELL_END = AW'(ROWS * COLS - 1);

  state_t        state, state_n;
  logic [4:0]    row_n;
  logic [6:0]    col_n;
  logic [AW-1:0] idx, idx_n;
  logic [7:0]    byte_q, byte_n;
  logic          newline;

  logic          ready_c, ena_c, rw_c;
  logic [AW-1:0] addr_c;
  logic [7:0]    wdata_c;
  logic [AW-1:0] put_addr;

  assign put_addr = AW'(cur_row) * COLS_AW + AW'(cur_col);

`ifdef TERM_CTRL_TAB_EN
  logic [7:0] tab_col;
  assign tab_col = {1'b0, cur_col | 7'd7} + 8'd1;
`endif

  // State, cursor, scroll/clear index and latched byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur_row <= '0;
      cur_col <= '0;
      idx     <= '0;
      byte_q  <= '0;
    end else begin
      state   <= state_n;
      cur_row <= row_n;
      cur_col <= col_n;
      idx     <= idx_n;
      byte_q  <= byte_n;
    end
  end

  // Byte decode, cursor movement and memory-port sequencing
  always_comb begin
    state_n = state;
    row_n   = cur_row;
    col_n   = cur_col;
    idx_n   = idx;
    byte_n  = byte_q;
    newline = 1'b0;
    ready_c = 1'b0;
    ena_c   = 1'b0;
    rw_c    = `MEM_READ;
    addr_c  = '0;
    wdata_c = '0;
    busy    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.char_valid) begin
          byte_n = bus.char_data;
          if (bus.char_data >= 8'h20 && bus.char_data <= 8'h7E) begin
            state_n = PUT;
          end else begin
            case (bus.char_data)
              8'h0A: newline = 1'b1;
              8'h0D: col_n = '0;
              8'h08: if (cur_col != '0) col_n = cur_col - 7'd1;
              8'h0C: begin
                idx_n   = '0;
                state_n = CLS;
              end
`ifdef TERM_CTRL_TAB_EN
              8'h09: begin
                if (tab_col >= 8'(COLS)) newline = 1'b1;
                else                     col_n   = tab_col[6:0];
              end
`endif
              default: ;
            endcase
          end
          // LF (and TAB past the last column) moves down, scrolling from the bottom row
          if (newline) begin
            col_n = '0;
            if (cur_row == ROW_LAST) begin
              idx_n   = '0;
              state_n = SCR_RD;
            end else begin
              row_n = cur_row + 5'd1;
            end
          end
        end
      end
      PUT: begin
        ena_c   = 1'b1;
        rw_c    = `MEM_WRITE;
        addr_c  = put_addr;
        wdata_c = byte_q;
        state_n = IDLE;
        if (cur_col == COL_LAST) begin
          col_n = '0;
          if (cur_row == ROW_LAST) begin
            idx_n   = '0;
            state_n = SCR_RD;
          end else begin
            row_n = cur_row + 5'd1;
          end
        end else begin
          col_n = cur_col + 7'd1;
        end
      end
      SCR_RD: begin
        busy    = 1'b1;
        ena_c   = 1'b1;
        addr_c  = idx + COLS_AW;
        state_n = SCR_WR;
      end
      SCR_WR: begin
        // Read data from the previous cycle's strobe lands one row up
        busy    = 1'b1;
        ena_c   = 1'b1;
        rw_c    = `MEM_WRITE;
        addr_c  = idx;
        wdata_c = bus.mem_rdata[7:0];
        if (idx == MOVE_END) begin
          idx_n   = LAST_ROW;
          state_n = SCR_CLR;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = SCR_RD;
        end
      end
      SCR_CLR, CLS: begin
        busy    = 1'b1;
        ena_c   = 1'b1;
        rw_c    = `MEM_WRITE;
        addr_c  = idx;
        wdata_c = 8'h20;
        if (idx == CELL_END) begin
          state_n = IDLE;
          if (state == CLS) begin
            row_n = '0;
            col_n = '0;
          end
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.char_ready = ready_c;
  assign bus.mem_ena    = ena_c;
  assign bus.mem_rw     = rw_c;
  assign bus.mem_addr   = 32'(addr_c);
  assign bus.mem_wdata  = {24'h0, wdata_c};

endmodule

// File: tb/tb_term_ctrl.sv
// tb_term_ctrl: directed and random byte streams into term_ctrl with a buffer model on its memory port.
// A screen/cursor reference model queues expected writes; a monitor pops and compares each write strobe.
module tb_term_ctrl;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
`ifdef TERM_CTRL_TAB_EN
  localparam int TAB_EXP = 16;
`else
  localparam int TAB_EXP = 12;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  term_ctrl_if bus();

  term_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int writes = 0;

  logic [7:0] mem     [CELLS];
  logic [7:0] ref_scr [CELLS];
  int mrow = 0;
  int mcol = 0;

  typedef struct packed {logic [11:0] a; logic [7:0] d;} wr_t;
  wr_t expq[$];

  logic        fill_req = 1'b0;
  logic        pre_req  = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [7:0]  pre_dat  = '0;
  logic        mon_en   = 1'b0;

  function automatic logic [7:0] fill_pat(int a);
    return 8'((a * 7 + 3) % 256);
  endfunction

  // Terminal buffer: 1-cycle registered read, write on strobe
  always @(posedge clk) begin
    if (fill_req) for (int a = 0; a < CELLS; a++) mem[a] <= fill_pat(a);
    if (pre_req) mem[pre_addr] <= pre_dat;
    if (rst && bus.mem_ena && bus.mem_addr < CELLS) begin
      if (bus.mem_rw) mem[bus.mem_addr[11:0]] <= bus.mem_wdata[7:0];
      else            bus.mem_rdata <= {24'h0, mem[bus.mem_addr[11:0]]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_cur(input string name, input int r, input int c);
    chk({name, "_row"}, 32'(cur_row), 32'(r));
    chk({name, "_col"}, 32'(cur_col), 32'(c));
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ready"}, 32'(bus.char_ready), 32'd1);
    chk({name, "_ena"},   32'(bus.mem_ena),    32'd0);
    chk({name, "_rw"},    32'(bus.mem_rw),     32'd0);
    chk({name, "_addr"},  bus.mem_addr,        32'd0);
    chk({name, "_wdata"}, bus.mem_wdata,       32'd0);
    chk({name, "_busy"},  32'(busy),           32'd0);
    chk_cur(name, 0, 0);
  endtask

  // ---------------- reference model ----------------
  function automatic void push_wr(int a, logic [7:0] d);
    wr_t e;
    e.a = 12'(a);
    e.d = d;
    expq.push_back(e);
    ref_scr[a] = d;
  endfunction

  function automatic void do_scroll();
    for (int a = 0; a < (ROWS - 1) * COLS; a++) push_wr(a, ref_scr[a + COLS]);
    for (int a = (ROWS - 1) * COLS; a < CELLS; a++) push_wr(a, 8'h20);
  endfunction

  function automatic void model_newline();
    mcol = 0;
    if (mrow == ROWS - 1) do_scroll();
    else mrow++;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    int t;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(mrow * COLS + mcol, b);
      mcol++;
      if (mcol == COLS) model_newline();
    end else if (b == 8'h0A) begin
      model_newline();
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      for (int a = 0; a < CELLS; a++) push_wr(a, 8'h20);
      mrow = 0;
      mcol = 0;
    end else if (b == 8'h09) begin
`ifdef TERM_CTRL_TAB_EN
      t = (mcol | 7) + 1;
      if (t >= COLS) model_newline();
      else mcol = t;
`else
      t = mcol;
`endif
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, output int busy_cyc);
    int waited;
    busy_cyc = 0;
    waited   = 0;
    model_byte(b);
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    while (!bus.char_ready && waited < 10000) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      waited++;
    end
    if (waited >= 10000) begin
      chk("accept_timeout", 32'(waited), 32'd0);
      bus.char_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.char_valid = 1'b0;
      bus.char_data  = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!(bus.char_ready && !busy && !bus.mem_ena) && waited < 10000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 10000) chk("idle_timeout", 32'(waited), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst && bus.mem_ena) begin
        strobes++;
        chk("addr_range", 32'(bus.mem_addr < CELLS), 32'd1);
        if (bus.mem_rw == 1'b1) begin
          writes++;
          if (expq.size() == 0) begin
            chk("unexpected_write_addr", bus.mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            chk("wr_addr", bus.mem_addr, 32'(e.a));
            chk("wr_data", bus.mem_wdata, 32'(e.d));
          end
        end
      end
    end
  end

  initial begin
    #1800000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int bc;
    int d0;
    int r;
    int bad;
    logic [7:0] b;
    logic [7:0] others [7];
    others = '{8'h00, 8'h01, 8'h07, 8'h1B, 8'h7F, 8'h80, 8'hFF};
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    for (int a = 0; a < CELLS; a++) ref_scr[a] = fill_pat(a);
    rst = 1'b0;
    fill_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 fill_req = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    mon_en = 1'b1;

    // single printable character
    send_byte(8'h41, bc);
    @(negedge clk);
    chk("A_ena",   32'(bus.mem_ena),    32'd1);
    chk("A_rw",    32'(bus.mem_rw),     32'd1);
    chk("A_addr",  bus.mem_addr,        32'd0);
    chk("A_wdata", bus.mem_wdata,       32'h41);
    chk("A_ready", 32'(bus.char_ready), 32'd0);
    @(negedge clk);
    chk("A_ena_after",   32'(bus.mem_ena),    32'd0);
    chk("A_ready_after", 32'(bus.char_ready), 32'd1);
    wait_idle();
    chk_cur("A_cursor", 0, 1);

    // CR: no bus activity
    d0 = strobes;
    send_byte(8'h0D, bc);
    wait_idle();
    chk_cur("cr0", 0, 0);
    chk("cr0_strobes", 32'(strobes - d0), 32'd0);

    // full row wraps to next row without scrolling
    d0 = writes;
    repeat (COLS) send_byte(8'h78, bc);
    wait_idle();
    chk_cur("row_wrap", 1, 0);
    chk("row_wrap_writes", 32'(writes - d0), 32'd70);
    chk("row_wrap_mem69", 32'(mem[69]), 32'h78);

    // scroll from the bottom row with a byte held during busy
    @(negedge clk);
    pre_addr = 12'd70;
    pre_dat  = 8'h42;
    pre_req  = 1'b1;
    @(posedge clk);
    #1 pre_req = 1'b0;
    ref_scr[70] = 8'h42;
    repeat (28) send_byte(8'h0A, bc);
    repeat (5) send_byte(8'h79, bc);
    wait_idle();
    chk_cur("pre_scroll", 29, 5);
    send_byte(8'h0A, bc);
    send_byte(8'h71, bc);
    chk("scroll_busy_cycles", 32'(bc), 32'd4130);
    wait_idle();
    chk_cur("post_scroll", 29, 1);
    chk("scroll_mem0",    32'(mem[0]),    32'h42);
    chk("scroll_mem2030", 32'(mem[2030]), 32'h71);
    chk("scroll_mem2031", 32'(mem[2031]), 32'h20);
    chk("scroll_mem2099", 32'(mem[2099]), 32'h20);

    // clear screen
    d0 = writes;
    send_byte(8'h0C, bc);
    wait_idle();
    chk("cls_writes", 32'(writes - d0), 32'd2100);
    chk_cur("cls", 0, 0);

    // backspace at column 0, CR mid-row
    repeat (3) send_byte(8'h0A, bc);
    wait_idle();
    chk_cur("row3", 3, 0);
    d0 = strobes;
    send_byte(8'h08, bc);
    wait_idle();
    chk_cur("bs_col0", 3, 0);
    chk("bs_strobes", 32'(strobes - d0), 32'd0);
    repeat (9) send_byte(8'h7A, bc);
    wait_idle();
    chk_cur("row3_col9", 3, 9);
    d0 = strobes;
    send_byte(8'h0D, bc);
    wait_idle();
    chk_cur("cr_row3", 3, 0);
    chk("cr_strobes", 32'(strobes - d0), 32'd0);

    // TAB from column 12
    send_byte(8'h0C, bc);
    repeat (12) send_byte(8'h62, bc);
    wait_idle();
    chk_cur("pre_tab", 0, 12);
    send_byte(8'h09, bc);
    wait_idle();
    chk_cur("tab", 0, TAB_EXP);

    // random stream against the reference model
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75)      b = 8'($urandom_range(32, 126));
      else if (r < 83) b = 8'h0A;
      else if (r < 88) b = 8'h0D;
      else if (r < 93) b = 8'h08;
      else if (r < 96) b = 8'h09;
      else if (r < 97) b = 8'h0C;
      else             b = others[$urandom_range(0, 6)];
      send_byte(b, bc);
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        chk_cur("rnd", mrow, mcol);
      end
    end
    wait_idle();
    chk_cur("rnd_end", mrow, mcol);
    chk("exp_queue_empty", 32'(expq.size()), 32'd0);
    bad = 0;
    for (int a = 0; a < CELLS; a++) if (mem[a] !== ref_scr[a]) bad++;
    chk("screen_mismatch_cells", 32'(bad), 32'd0);

    // asynchronous reset in the middle of a scroll
    while (mrow != ROWS - 1) send_byte(8'h0A, bc);
    send_byte(8'h0A, bc);
    repeat (100) @(negedge clk);
    chk("midscroll_busy", 32'(busy), 32'd1);
    #3;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset("async_reset");
    expq.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/term_ctrl.md
Name: term_ctrl

Overview:
- Character-stream front end for the text terminal buffer (70x30 byte array, one byte per cell, registered 1-cycle read).
- Accepts one byte per valid/ready handshake and interprets it as a printable character or a control code.
- Drives the buffer's memory-port (ena/rw/addr/wdata/rdata) to place characters, track the cursor, clear the screen and scroll.
- Sits directly upstream of the terminal buffer. Its data source is a CPU putchar port or a UART receiver.

Parameters:
- COLS, 70, characters per row
- ROWS, 30, rows on screen
- AW, 12, buffer address width; must satisfy 2^AW >= COLS*ROWS

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous active-low reset
- char_valid  input  1  source has a byte
- char_data  input  8  byte to interpret
- char_ready  output  1  block can accept a byte this cycle
- mem_ena  output  1  buffer access strobe
- mem_rw  output  1  `MEM_READ or `MEM_WRITE
- mem_addr  output  `DATA_BUS  cell index, upper bits zero
- mem_wdata  output  `DATA_BUS  {24'b0, byte}
- mem_rdata  input  `DATA_BUS  buffer read data; valid the cycle after a read strobe
- cur_row  output  5  cursor row, 0..ROWS-1
- cur_col  output  7  cursor column, 0..COLS-1
- busy  output  1  scroll or clear in progress

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, char_ready=1, mem_ena=0, mem_rw=`MEM_READ, mem_addr=0, mem_wdata=0, cur_row=0, cur_col=0, busy=0.
  - The buffer is not cleared on reset.
- Handshake:
  - A byte is accepted when char_valid && char_ready.
  - char_ready=1 only in IDLE. Bytes are latched on acceptance.
  - char_valid held while not ready is neither consumed nor lost.
- States: IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CLS.
- Decode of the accepted byte; IDLE is left at the next cycle:
  - 0x20..0x7E → PUT.
    - PUT: mem_ena=1, rw=`MEM_WRITE, addr=cur_row*COLS+cur_col, wdata=byte.
    - Then cur_col+1. If cur_col was COLS-1: col=0 and row+1.
    - If row was ROWS-1 the write is followed by a scroll, entered at SCR_RD.
  - 0x0A (LF): col=0. Row+1, or scroll if row=ROWS-1. No write.
  - 0x0D (CR): col=0, no bus activity, stay IDLE (ready next cycle).
  - 0x08 (BS): col-1 if col>0, else unchanged. No erase.
  - 0x0C (FF): → CLS.
  - All other bytes: accepted and dropped.
- Scroll:
  - For i = 0 .. (ROWS-1)*COLS-1:
    - SCR_RD: read addr i+COLS.
    - SCR_WR: write addr i with mem_rdata[7:0].
  - Then SCR_CLR writes 0x20 to the last row, addresses (ROWS-1)*COLS .. ROWS*COLS-1, one per cycle.
  - Duration is 2*COLS*(ROWS-1)+COLS cycles (4130 at defaults). busy=1 throughout.
  - The cursor ends at (ROWS-1, 0) for LF and wrap-around.
- CLS:
  - Writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle (2100 cycles). busy=1.
  - Cursor goes to (0,0) on completion.
- Address arithmetic is done at AW bits and zero-extended to `DATA_BUS. Addresses never exceed ROWS*COLS-1.
- mem_ena=0 in IDLE. Every strobe is a single cycle.
- Reset mid-scroll or mid-clear aborts immediately. The buffer is left partially updated; this is accepted behaviour.

Optional Feature:
- TERM_CTRL_TAB_EN defined: 0x09 sets col=(col|7)+1. If that is >= COLS, it acts as LF, including a scroll at the last row. No write.
- Undefined: 0x09 is accepted and dropped like any other unhandled code.

Test Plan:
- Reset, then send 'A'(0x41):
  - exactly one write, addr=0, wdata=0x41, one cycle after acceptance;
  - cursor=(0,1); char_ready low for 1 cycle.
- Send 70 x 'x' from (0,0):
  - last write at addr=69;
  - cursor=(1,0); no scroll.
- Preload row1 col0 with 0x42, set cursor (29,5), send 0x0A:
  - busy=1 for 4130 cycles;
  - addr 0 then holds 0x42; addrs 2030..2099 hold 0x20;
  - cursor=(29,0); char_valid held throughout is not accepted until busy=0.
- Send 0x0C:
  - 2100 writes of 0x20 at addrs 0..2099;
  - cursor=(0,0).
- Cursor (3,0):
  - send 0x08 → cursor unchanged, no write;
  - send 0x0D at (3,9) → (3,0), no bus activity.
- Cursor (0,12), send 0x09:
  - with TERM_CTRL_TAB_EN → (0,16);
  - without → (0,12).
- Also assert rst low mid-scroll → all outputs return to reset values asynchronously.
